// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//  Shared definitions for the CPU-side memory port arbiter.
//  Contents:
//    MEM_AW / MEM_DW   default byte-address and data widths
//    RAM_RD_LATENCY    RAM read latency in cycles (m_rdata follows m_en by one)
//    STREAK_W          width of the I-starvation streak counter
//    port_id_e         requester identity (instruction fetch / load-store)
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned MEM_AW         = 32;
  localparam int unsigned MEM_DW         = 32;
  localparam int unsigned RAM_RD_LATENCY = 1;
  localparam int unsigned STREAK_W       = 4;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

endpackage

// File: rtl/mem_resp_tracker.sv
// -----------------------------------------------------------------------------
// mem_resp_tracker
//  Remembers which requester owns the read issued to the RAM this cycle and,
//  one cycle later, raises that owner's rvalid while the RAM data is presented.
//  Ports:
//    clk, rst            clock, synchronous active-high reset
//    rd_gnt              a read was issued to the RAM this cycle
//    rd_owner            owner of that read
//    m_rdata             RAM read data (valid the cycle after rd_gnt)
//    i_rvalid, i_rdata   instruction-fetch response
//    d_rvalid, d_rdata   load/store response
//    resp_v, resp_owner  tracker state, exposed for observation
// -----------------------------------------------------------------------------
module mem_resp_tracker
  import mem_pkg::*;
#(
  parameter int unsigned DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_gnt,
  input  port_id_e      rd_owner,
  input  logic [DW-1:0] m_rdata,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          resp_v,
  output port_id_e      resp_owner
);

  logic     resp_v_q, resp_v_d;
  port_id_e resp_owner_q, resp_owner_d;

  always_comb begin
    resp_v_d     = rd_gnt;
    resp_owner_d = rd_gnt ? rd_owner : resp_owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_v_q     <= 1'b0;
      resp_owner_q <= PORT_I;
    end else begin
      resp_v_q     <= resp_v_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Both data outputs carry the RAM data; only the owner's rvalid qualifies it.
  always_comb begin
    i_rvalid   = resp_v_q && (resp_owner_q == PORT_I);
    d_rvalid   = resp_v_q && (resp_owner_q == PORT_D);
    i_rdata    = m_rdata;
    d_rdata    = m_rdata;
    resp_v     = resp_v_q;
    resp_owner = resp_owner_q;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one single-port synchronous RAM between the instruction-fetch port (I)
//  and the load/store port (D). At most one RAM access per cycle; D wins ties
//  unless it has already won MAX_STREAK consecutive ties, then I is served.
//  Handshake: a requester holds req (and its address/data) until the
//  combinational gnt is seen high in a cycle; that cycle is the accept cycle.
//  For reads, the owner's rvalid is high exactly one cycle after the accept and
//  rdata is only meaningful while that rvalid is high.
//  Ports:
//    clk, rst                              clock, synchronous active-high reset
//    i_req, i_addr, i_gnt                  I read request / accept
//    i_rvalid, i_rdata                     I read response
//    d_req, d_we, d_be, d_addr, d_wdata    D request (read or byte-masked write)
//    d_gnt, d_rvalid, d_rdata              D accept / read response
//    m_en, m_we, m_be, m_addr, m_wdata     RAM command (word address)
//    m_rdata                               RAM read data, one cycle after m_en
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW         = MEM_AW,
  parameter int unsigned DW         = MEM_DW,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-3:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                max_hit;
  port_id_e            rd_owner;
  logic                resp_v;
  port_id_e            resp_owner;

  // Byte-offset bits never reach the RAM; alignment is the requester's job.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0], resp_v, resp_owner};

  // Grant: D has priority unless I has been passed over MAX_STREAK times.
  always_comb begin
    max_hit = (streak_q == STREAK_MAX);
    d_gnt   = !rst && d_req && !(i_req && max_hit);
    i_gnt   = !rst && i_req && !d_gnt;
  end

  // Streak counts consecutive D grants that made a waiting I lose; it resets
  // as soon as I is served or stops asking, and saturates at MAX_STREAK.
  always_comb begin
    streak_d = streak_q;
    if (i_gnt || !i_req) begin
      streak_d = '0;
    end else if (d_gnt && !max_hit) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // RAM command mux from whichever port holds the grant.
  always_comb begin
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_be     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    rd_owner = PORT_I;
    if (d_gnt) begin
      m_en     = 1'b1;
      m_we     = d_we;
      m_be     = d_we ? d_be : '0;
      m_addr   = d_addr[AW-1:2];
      m_wdata  = d_wdata;
      rd_owner = PORT_D;
    end else if (i_gnt) begin
      m_en     = 1'b1;
      m_addr   = i_addr[AW-1:2];
    end
  end

  mem_resp_tracker #(
    .DW (DW)
  ) u_resp_tracker (
    .clk        (clk),
    .rst        (rst),
    .rd_gnt     (m_en && !m_we),
    .rd_owner   (rd_owner),
    .m_rdata    (m_rdata),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .resp_v     (resp_v),
    .resp_owner (resp_owner)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//  Drives both requester ports cycle by cycle, models the RAM behind the
//  arbiter, predicts grants/streak from an independent reference, and checks
//  read responses against a per-owner expected-data queue.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int BW         = DW / 8;
  localparam int MAX_STREAK = 4;
  localparam int RAM_WORDS  = 64;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [BW-1:0] m_be;
  logic [AW-3:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int k);
    return 32'hA500_0000 | DW'(k);
  endfunction

  // ---------------- RAM model (reloaded on reset) ----------------
  logic [DW-1:0] ram [RAM_WORDS];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RAM_WORDS; k++) ram[k] <= init_word(k);
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < BW; b++)
          if (m_be[b]) ram[m_addr[5:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= ram[m_addr[5:0]];
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [RAM_WORDS];
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  int            ref_streak;
  logic          pend_i, pend_d;
  int            n_tests, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check the
  // response to last cycle's grant and this cycle's predicted grant.
  task automatic do_cycle(input logic r, input logic ir, input logic [AW-1:0] ia,
                          input logic dr, input logic dwe, input logic [BW-1:0] dbe,
                          input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                          output logic ig_exp, output logic dg_exp);
    logic [DW-1:0] exp_v;
    @(negedge clk);
    rst = r; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    #1;
    check_eq("streak", 64'(dut.streak_q), 64'(ref_streak));
    check_eq("i_rvalid", 64'(i_rvalid), 64'(pend_i));
    check_eq("d_rvalid", 64'(d_rvalid), 64'(pend_d));
    if (pend_i) begin
      exp_v = exp_i_q.pop_front();
      check_eq("i_rdata", 64'(i_rdata), 64'(exp_v));
    end
    if (pend_d) begin
      exp_v = exp_d_q.pop_front();
      check_eq("d_rdata", 64'(d_rdata), 64'(exp_v));
    end

    dg_exp = !r && dr && !(ir && ref_streak == MAX_STREAK);
    ig_exp = !r && ir && !dg_exp;
    check_eq("i_gnt", 64'(i_gnt), 64'(ig_exp));
    check_eq("d_gnt", 64'(d_gnt), 64'(dg_exp));
    check_eq("m_en", 64'(m_en), 64'(ig_exp || dg_exp));

    if (dg_exp) begin
      check_eq("m_we_d", 64'(m_we), 64'(dwe));
      check_eq("m_addr_d", 64'(m_addr), 64'(da[AW-1:2]));
      if (dwe) begin
        check_eq("m_be", 64'(m_be), 64'(dbe));
        check_eq("m_wdata", 64'(m_wdata), 64'(dwd));
        for (int b = 0; b < BW; b++)
          if (dbe[b]) ref_mem[da[7:2]][8*b +: 8] = dwd[8*b +: 8];
      end else begin
        exp_d_q.push_back(ref_mem[da[7:2]]);
      end
    end else if (ig_exp) begin
      check_eq("m_we_i", 64'(m_we), 64'd0);
      check_eq("m_addr_i", 64'(m_addr), 64'(ia[AW-1:2]));
      exp_i_q.push_back(ref_mem[ia[7:2]]);
    end else begin
      check_eq("m_we_idle", 64'(m_we), 64'd0);
      check_eq("m_be_idle", 64'(m_be), 64'd0);
    end

    pend_i = ig_exp;
    pend_d = dg_exp && !dwe;
    if (r) begin
      ref_streak = 0;
      for (int k = 0; k < RAM_WORDS; k++) ref_mem[k] = init_word(k);
    end else if (ig_exp || !ir) begin
      ref_streak = 0;
    end else if (dg_exp && ref_streak < MAX_STREAK) begin
      ref_streak = ref_streak + 1;
    end
  endtask

  task automatic idle_cycle();
    logic ig, dg;
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, ig, dg);
  endtask

  // ---------------- stimulus ----------------
  logic          ig, dg;
  logic          cur_ir, cur_dr, cur_dwe;
  logic [AW-1:0] cur_ia, cur_da;
  logic [BW-1:0] cur_dbe;
  logic [DW-1:0] cur_dwd;

  initial begin
    n_tests = 0; n_fail = 0;
    ref_streak = 0; pend_i = 1'b0; pend_d = 1'b0;
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < RAM_WORDS; k++) ref_mem[k] = init_word(k);

    // Reset with both requests high: nothing granted.
    repeat (2) do_cycle(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, '0, 32'h10, '0, ig, dg);
    idle_cycle();

    // I-only read of byte address 0x8 (word 2).
    do_cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0, '0, ig, dg);
    idle_cycle();

    // D byte-1 write to 0x10, then read it back.
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD, ig, dg);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 32'h10, '0, ig, dg);
    idle_cycle();

    // Contention: both held high for 10 cycles -> D,D,D,D,I,D,D,D,D,I.
    repeat (10) do_cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, '0, 32'h24, '0, ig, dg);
    idle_cycle();

    // Mixed random traffic; a request is held until granted or dropped.
    cur_ir = 1'b0; cur_dr = 1'b0; ig = 1'b0; dg = 1'b0;
    cur_ia = '0; cur_da = '0; cur_dwe = 1'b0; cur_dbe = '0; cur_dwd = '0;
    for (int n = 0; n < 300; n++) begin
      if (!cur_ir || ig || $urandom_range(0, 15) == 0) begin
        cur_ir = 1'($urandom_range(0, 1));
        cur_ia = AW'($urandom_range(0, 255));
      end
      if (!cur_dr || dg || $urandom_range(0, 15) == 0) begin
        cur_dr  = ($urandom_range(0, 3) != 0);
        cur_dwe = ($urandom_range(0, 2) == 0);
        cur_dbe = BW'($urandom_range(0, 15));
        cur_da  = AW'($urandom_range(0, 255));
        cur_dwd = $urandom;
      end
      do_cycle(1'b0, cur_ir, cur_ia, cur_dr, cur_dwe, cur_dbe, cur_da, cur_dwd, ig, dg);
    end
    idle_cycle();

    // Reset arriving with a D read pending: no grant, no response, streak cleared.
    repeat (2) do_cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, '0, 32'h34, '0, ig, dg);
    do_cycle(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, '0, 32'h34, '0, ig, dg);
    idle_cycle();
    idle_cycle();

    check_eq("exp_i_q_empty", 64'(exp_i_q.size()), 64'd0);
    check_eq("exp_d_q_empty", 64'(exp_d_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // A read response must never go to both owners at once.
  always @(negedge clk) begin
    if (i_rvalid === 1'b1 && d_rvalid === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL both_rvalid: got i_rvalid=1 d_rvalid=1 expected at most one (t=%0t)", $time);
    end
  end

endmodule
